// File: rtl/lfsr_pkg.sv
// lfsr_pkg: FSM type, single-step XNOR LFSR function and maximal-length tap table
// shared by the LFSR stream generator.
package lfsr_pkg;
   typedef enum logic [1:0] {IDLE, RUN, LOCKED} fsm_t;
   // Bit k-1 set means a tap at stage k; XNOR and XOR maximal taps coincide.
   localparam logic [63:0] MAX_TAPS [0:64] = '{
      3:  64'h0000_0000_0000_0006,
      4:  64'h0000_0000_0000_000C,
      5:  64'h0000_0000_0000_0014,
      6:  64'h0000_0000_0000_0030,
      7:  64'h0000_0000_0000_0060,
      8:  64'h0000_0000_0000_00B8,
      9:  64'h0000_0000_0000_0110,
      10: 64'h0000_0000_0000_0240,
      11: 64'h0000_0000_0000_0500,
      12: 64'h0000_0000_0000_0829,
      13: 64'h0000_0000_0000_100D,
      14: 64'h0000_0000_0000_2015,
      15: 64'h0000_0000_0000_6000,
      16: 64'h0000_0000_0000_D008,
      17: 64'h0000_0000_0001_2000,
      18: 64'h0000_0000_0002_0400,
      19: 64'h0000_0000_0004_0023,
      20: 64'h0000_0000_0009_0000,
      21: 64'h0000_0000_0014_0000,
      22: 64'h0000_0000_0030_0000,
      23: 64'h0000_0000_0042_0000,
      24: 64'h0000_0000_00E1_0000,
      25: 64'h0000_0000_0120_0000,
      26: 64'h0000_0000_0200_0023,
      27: 64'h0000_0000_0400_0013,
      28: 64'h0000_0000_0900_0000,
      29: 64'h0000_0000_1400_0000,
      30: 64'h0000_0000_2000_0029,
      31: 64'h0000_0000_4800_0000,
      32: 64'h0000_0000_8020_0003,
      64: 64'hD800_0000_0000_0000,
      default: 64'h0
   };
   // Returns {next_reg, fb}; callers keep only their own low NUM_BITS of next_reg.
   function automatic logic [64:0] lfsr_step(input logic [63:0] cur, input logic [63:0] taps);
      logic fb;
      fb = ~^(cur & taps);
      return {cur[62:0], fb, fb};
   endfunction
endpackage

// File: rtl/lfsr_step_n.sv
// lfsr_step_n: STEPS single-bit XNOR LFSR shifts unrolled into one combinational beat.
module lfsr_step_n
   import lfsr_pkg::*;
#(
   parameter int NUM_BITS = 16,
   parameter int STEPS    = 1
) (
   input  logic [NUM_BITS-1:0] cur_reg,
   input  logic [NUM_BITS-1:0] taps,
   output logic [NUM_BITS-1:0] next_reg,
   output logic [STEPS-1:0]    fb_bits
);
   logic [NUM_BITS-1:0] chain [STEPS+1];
   assign chain[0] = cur_reg;
   for (genvar i = 0; i < STEPS; i++) begin : g_step
      logic [64:0] res;
      assign res        = lfsr_step(64'(chain[i]), 64'(taps));
      assign chain[i+1] = res[NUM_BITS:1];
      assign fb_bits[i] = res[0];
      if (NUM_BITS < 64) begin : g_pad
         logic [63-NUM_BITS:0] unused_hi;
         assign unused_hi = res[64:NUM_BITS+1];
      end
   end
   assign next_reg = chain[STEPS];
endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: XNOR LFSR beat generator with programmable taps and a valid/ready stream.
// LFSR_AUTO_RECOVER_EN: on lock-up clear the register and keep streaming instead of halting.
module lfsr_stream
   import lfsr_pkg::*;
#(
   parameter int                  NUM_BITS   = 16,
   parameter int                  STEPS      = 1,
   parameter logic [NUM_BITS-1:0] TAPS_RESET = NUM_BITS'(16'hD008)
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                E,
   input  logic                LOAD,
   input  logic [NUM_BITS-1:0] SEED,
   input  logic                TAP_WE,
   input  logic [NUM_BITS-1:0] TAP_IN,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic [STEPS-1:0]    OUT_DATA,
   output logic [NUM_BITS-1:0] STATE,
   output logic                LOCKUP
);
   if (NUM_BITS < 3 || NUM_BITS > 64) begin : g_bad_width
      $error("lfsr_stream: NUM_BITS must be 3..64");
   end
   if (STEPS < 1 || STEPS > NUM_BITS) begin : g_bad_steps
      $error("lfsr_stream: STEPS must be 1..NUM_BITS");
   end
   fsm_t                state_q, state_d;
   logic [NUM_BITS-1:0] reg_q, reg_d, taps_q, step_reg;
   logic [STEPS-1:0]    data_q, data_d, step_fb;
   logic                valid_q, valid_d, lockup_q, lockup_d;
   logic                all_ones, seed_ones, advance;
   lfsr_step_n #(.NUM_BITS(NUM_BITS), .STEPS(STEPS)) u_step (
      .cur_reg (reg_q),
      .taps    (taps_q),
      .next_reg(step_reg),
      .fb_bits (step_fb)
   );
   assign all_ones  = &reg_q;
   assign seed_ones = &SEED;
   // An all-ones register in RUN is treated as lock-up, never stepped through.
   assign advance   = !LOAD && state_q == RUN && !all_ones && E && (!valid_q || OUT_READY);
   always_comb begin
      state_d  = state_q;
      reg_d    = advance ? step_reg : reg_q;
      data_d   = advance ? step_fb : data_q;
      valid_d  = advance || (valid_q && !OUT_READY);
      lockup_d = lockup_q;
      if (LOAD) begin
         reg_d    = SEED;
         valid_d  = 1'b0;
         lockup_d = seed_ones;
`ifdef LFSR_AUTO_RECOVER_EN
         state_d  = RUN;
`else
         state_d  = seed_ones ? LOCKED : RUN;
`endif
      end else if (state_q == IDLE) begin
         state_d = E ? RUN : IDLE;
      end else if (state_q == RUN && all_ones) begin
         lockup_d = 1'b1;
`ifdef LFSR_AUTO_RECOVER_EN
         reg_d    = '0;
`else
         state_d  = LOCKED;
`endif
      end
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         reg_q    <= '0;
         taps_q   <= TAPS_RESET;
         data_q   <= '0;
         valid_q  <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         reg_q    <= reg_d;
         taps_q   <= TAP_WE ? TAP_IN : taps_q;
         data_q   <= data_d;
         valid_q  <= valid_d;
         lockup_q <= lockup_d;
      end
   end
   assign OUT_VALID = valid_q;
   assign OUT_DATA  = data_q;
   assign STATE     = reg_q;
   assign LOCKUP    = lockup_q;
endmodule
